// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin scheduler that shares one UART_Tx serializer among
//            NUM_REQ requesters. Accepts one- or two-byte messages, sends
//            them LSB first and paces each byte on the UART Busy flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int TO_WIDTH     = 3,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic [NUM_REQ-1:0]     Req_valid,
   input  logic [16*NUM_REQ-1:0]  Req_data,
   input  logic [NUM_REQ-1:0]     Req_two_byte,
   output logic [NUM_REQ-1:0]     Req_ack,
   output logic [7:0]             Tx_data,
   output logic                   Tx_valid,
   input  logic                   Tx_busy,
   output logic                   Arb_busy,
   output logic                   Timeout_err
);

   localparam int                  IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0]    c_LAST_RST = IDX_W'(NUM_REQ - 1);
   localparam logic [TO_WIDTH-1:0] c_TIMEOUT  = TO_WIDTH'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   // FSM and message state
   state_t               state_q,      state_d;
   logic [IDX_W-1:0]     last_grant_q, last_grant_d;
   logic [7:0]           msb_q,        msb_d;
   logic                 msb_pend_q,   msb_pend_d;
   logic [TO_WIDTH-1:0]  to_cnt_q,     to_cnt_d;

   // Registered outputs
   logic                 tx_valid_q,    tx_valid_d;
   logic [7:0]           tx_data_q,     tx_data_d;
   logic [NUM_REQ-1:0]   req_ack_q,     req_ack_d;
   logic                 arb_busy_q,    arb_busy_d;
   logic                 timeout_err_q, timeout_err_d;

   // Arbitration results
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_found;
   logic [IDX_W-1:0]     cand_idx;
   logic [15:0]          sel_data;
   logic                 sel_two;

   // Round-robin search: first valid requester strictly after last_grant,
   // wrapping so that last_grant itself is considered last.
   always_comb begin
      grant_idx   = last_grant_q;
      grant_found = 1'b0;
      cand_idx    = last_grant_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (!grant_found && Req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // Route the winning requester's message fields.
   always_comb begin
      sel_data = 16'h0000;
      sel_two  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_data = Req_data[16*i +: 16];
            sel_two  = Req_two_byte[i];
         end
      end
   end

   // Next-state and next-output logic; every output is registered so the
   // values computed here appear one cycle later.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      msb_d         = msb_q;
      msb_pend_d    = msb_pend_q;
      to_cnt_d      = to_cnt_q;
      tx_valid_d    = 1'b0;
      tx_data_d     = tx_data_q;
      req_ack_d     = '0;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Never offer a byte while the serializer reports a frame.
            if (grant_found && !Tx_busy) begin
               state_d              = ST_ISSUE;
               last_grant_d         = grant_idx;
               msb_d                = sel_data[15:8];
               msb_pend_d           = sel_two;
               tx_valid_d           = 1'b1;
               tx_data_d            = sel_data[7:0];
               req_ack_d[grant_idx] = 1'b1;
            end
         end

         ST_ISSUE: begin
            state_d  = ST_WAIT_BUSY;
            to_cnt_d = '0;
         end

         ST_WAIT_BUSY: begin
            if (Tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_WIDTH'(1);
               if (to_cnt_d == c_TIMEOUT) begin
                  // Serializer never acknowledged the byte: drop the rest.
                  timeout_err_d = 1'b1;
                  msb_pend_d    = 1'b0;
                  state_d       = ST_IDLE;
               end
            end
         end

         ST_WAIT_DONE: begin
            if (!Tx_busy) begin
               if (msb_pend_q) begin
                  state_d    = ST_ISSUE;
                  tx_valid_d = 1'b1;
                  tx_data_d  = msb_q;
                  msb_pend_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      arb_busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= c_LAST_RST;
         msb_q         <= 8'h00;
         msb_pend_q    <= 1'b0;
         to_cnt_q      <= '0;
         tx_valid_q    <= 1'b0;
         tx_data_q     <= 8'h00;
         req_ack_q     <= '0;
         arb_busy_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         msb_q         <= msb_d;
         msb_pend_q    <= msb_pend_d;
         to_cnt_q      <= to_cnt_d;
         tx_valid_q    <= tx_valid_d;
         tx_data_q     <= tx_data_d;
         req_ack_q     <= req_ack_d;
         arb_busy_q    <= arb_busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign Tx_valid    = tx_valid_q;
   assign Tx_data     = tx_data_q;
   assign Req_ack     = req_ack_q;
   assign Arb_busy    = arb_busy_q;
   assign Timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 2;
   localparam int TO_WIDTH     = 3;
   localparam int BUSY_TIMEOUT = 4;

   localparam int U_MANUAL = 0;
   localparam int U_NORMAL = 1;
   localparam int U_NEVER  = 2;

   logic                  CLK          = 1'b0;
   logic                  Reset        = 1'b0;
   logic [NUM_REQ-1:0]    Req_valid    = '0;
   logic [16*NUM_REQ-1:0] Req_data     = '0;
   logic [NUM_REQ-1:0]    Req_two_byte = '0;
   logic [NUM_REQ-1:0]    Req_ack;
   logic [7:0]            Tx_data;
   logic                  Tx_valid;
   logic                  Tx_busy      = 1'b0;
   logic                  Arb_busy;
   logic                  Timeout_err;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .TO_WIDTH     (TO_WIDTH),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .Req_valid    (Req_valid),
      .Req_data     (Req_data),
      .Req_two_byte (Req_two_byte),
      .Req_ack      (Req_ack),
      .Tx_data      (Tx_data),
      .Tx_valid     (Tx_valid),
      .Tx_busy      (Tx_busy),
      .Arb_busy     (Arb_busy),
      .Timeout_err  (Timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: message-level view. It remembers whether a message is
   // in flight, how many clock edges have passed since the last byte was
   // offered, whether the serializer has acknowledged it, and any MSB left.
   // ---------------------------------------------------------------------
   bit                 m_free = 1'b1;
   int                 m_last = NUM_REQ - 1;
   bit                 m_pend = 1'b0;
   logic [7:0]         m_msb  = 8'h00;
   bit                 m_seen = 1'b0;
   int                 m_age  = 0;
   int                 m_win;
   logic [31:0]        m_word;
   logic               e_valid = 1'b0;
   logic [7:0]         e_data  = 8'h00;
   logic [NUM_REQ-1:0] e_ack   = '0;
   logic               e_arb   = 1'b0;
   logic               e_terr  = 1'b0;

   initial forever begin
      @(posedge CLK or negedge Reset);
      if (!Reset) begin
         m_free = 1'b1; m_last = NUM_REQ - 1; m_pend = 1'b0; m_seen = 1'b0; m_age = 0;
         e_valid = 1'b0; e_data = 8'h00; e_ack = '0; e_arb = 1'b0; e_terr = 1'b0;
      end else begin
         e_valid = 1'b0;
         e_ack   = '0;
         e_terr  = 1'b0;
         if (m_free) begin
            if (Req_valid != '0 && !Tx_busy) begin
               m_win = m_last;
               for (int k = 1; k <= NUM_REQ; k++) begin
                  if (((Req_valid >> ((m_last + k) % NUM_REQ)) & 1) != 0) begin
                     m_win = (m_last + k) % NUM_REQ;
                     break;
                  end
               end
               m_word  = 32'(Req_data >> (16 * m_win));
               m_pend  = (((Req_two_byte >> m_win) & 1) != 0);
               m_msb   = m_word[15:8];
               e_valid = 1'b1;
               e_data  = m_word[7:0];
               e_ack   = NUM_REQ'(1) << m_win;
               m_last  = m_win;
               m_free  = 1'b0;
               m_seen  = 1'b0;
               m_age   = 0;
            end
         end else begin
            // m_age counts edges since the edge that raised the last Tx_valid;
            // the first of those is the pulse cycle itself and is ignored.
            m_age++;
            if (m_age > 1) begin
               if (!m_seen) begin
                  if (Tx_busy) begin
                     m_seen = 1'b1;
                  end else if (m_age == BUSY_TIMEOUT + 1) begin
                     e_terr = 1'b1;
                     m_pend = 1'b0;
                     m_free = 1'b1;
                  end
               end else if (!Tx_busy) begin
                  if (m_pend) begin
                     e_valid = 1'b1;
                     e_data  = m_msb;
                     m_pend  = 1'b0;
                     m_seen  = 1'b0;
                     m_age   = 0;
                  end else begin
                     m_free = 1'b1;
                  end
               end
            end
         end
         e_arb = !m_free;
      end
   end

   // ---------------------------------------------------------------------
   // Compare process and event logs used by the directed scenarios.
   // ---------------------------------------------------------------------
   logic [7:0] tx_log[$];
   int         txc_log[$];
   int         ack_log[$];
   int         to_log[$];
   int         mon_cyc = 0;

   initial forever begin
      @(negedge CLK);
      mon_cyc++;
      if (Reset) begin
         chk("tx_valid",    32'(Tx_valid),    32'(e_valid));
         chk("tx_data",     32'(Tx_data),     32'(e_data));
         chk("req_ack",     32'(Req_ack),     32'(e_ack));
         chk("arb_busy",    32'(Arb_busy),    32'(e_arb));
         chk("timeout_err", 32'(Timeout_err), 32'(e_terr));
         if (Tx_valid) begin
            tx_log.push_back(Tx_data);
            txc_log.push_back(mon_cyc);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (Req_ack[i]) ack_log.push_back(i);
         end
         if (Timeout_err) to_log.push_back(mon_cyc);
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus: requesters and a UART Busy model, stepped on falling edges.
   // ---------------------------------------------------------------------
   int u_mode   = U_MANUAL;
   int u_up     = 0;
   int u_dn     = 0;
   bit hold_all = 1'b0;
   bit auto_req = 1'b0;

   task automatic post(input int i, input logic [15:0] d, input logic two);
      Req_valid[i]         = 1'b1;
      Req_data[16*i +: 16] = d;
      Req_two_byte[i]      = two;
   endtask

   task automatic uart_step();
      if (u_up > 0) begin
         u_up--;
         if (u_up == 0) Tx_busy = 1'b1;
      end else if (Tx_busy && u_mode != U_MANUAL) begin
         if (u_dn > 0) u_dn--;
         if (u_dn == 0) Tx_busy = 1'b0;
      end
      if (Tx_valid && u_mode == U_NORMAL) begin
         u_dn = $urandom_range(1, 5);
         u_up = $urandom_range(0, 2);
         if (u_up == 0) Tx_busy = 1'b1;
      end
   endtask

   task automatic req_step();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (Req_ack[i]) begin
            Req_valid[i] = 1'b0;
            if (hold_all || (auto_req && $urandom_range(0, 1) == 1))
               post(i, 16'($urandom), 1'($urandom));
         end else if (auto_req && !Req_valid[i] && $urandom_range(0, 3) == 0) begin
            post(i, 16'($urandom), 1'($urandom));
         end
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      uart_step();
      req_step();
   endtask

   task automatic clear_logs();
      tx_log.delete(); txc_log.delete(); ack_log.delete(); to_log.delete();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((Req_valid != '0 || Arb_busy || Tx_busy) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(Req_valid != '0 || Arb_busy), 32'd0);
   endtask

   task automatic wait_acks(input int n, input int budget);
      int k = 0;
      while (ack_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("wait_acks", 32'(ack_log.size() >= n), 32'd1);
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k = 0;
      while (tx_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("wait_tx", 32'(tx_log.size() >= n), 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_tx_valid",    32'(Tx_valid),    32'd0);
      chk("rst_tx_data",     32'(Tx_data),     32'd0);
      chk("rst_req_ack",     32'(Req_ack),     32'd0);
      chk("rst_arb_busy",    32'(Arb_busy),    32'd0);
      chk("rst_timeout_err", 32'(Timeout_err), 32'd0);
      Reset = 1'b1;
      repeat (2) tick();

      // Single one-byte request from requester 0
      post(0, 16'h0055, 1'b0);
      tick();
      chk("t1_tx_valid", 32'(Tx_valid), 32'd1);
      chk("t1_tx_data",  32'(Tx_data),  32'h55);
      chk("t1_req_ack",  32'(Req_ack),  32'b01);
      tick();
      Tx_busy = 1'b1;
      repeat (3) tick();
      chk("t1_arb_busy_hold", 32'(Arb_busy), 32'd1);
      Tx_busy = 1'b0;
      tick();
      chk("t1_arb_busy_fall", 32'(Arb_busy), 32'd0);
      repeat (2) tick();

      // Two-byte message from requester 1, LSB first
      clear_logs();
      u_mode = U_NORMAL;
      post(1, 16'hA5C3, 1'b1);
      wait_tx(2, 60);
      drain(60);
      chk("t2_tx_count", 32'(tx_log.size()), 32'd2);
      if (tx_log.size() >= 2) begin
         chk("t2_lsb", 32'(tx_log[0]), 32'hC3);
         chk("t2_msb", 32'(tx_log[1]), 32'hA5);
      end
      chk("t2_ack_count", 32'(ack_log.size()), 32'd1);

      // Contention: both requesters continuously requesting
      clear_logs();
      hold_all = 1'b1;
      post(0, 16'h1111, 1'b0);
      post(1, 16'h2222, 1'b1);
      wait_acks(4, 300);
      hold_all = 1'b0;
      if (ack_log.size() >= 4) begin
         chk("t3_grant0", 32'(ack_log[0]), 32'd0);
         chk("t3_grant1", 32'(ack_log[1]), 32'd1);
         chk("t3_grant2", 32'(ack_log[2]), 32'd0);
         chk("t3_grant3", 32'(ack_log[3]), 32'd1);
      end
      drain(300);

      // Timeout: serializer never raises Busy, MSB must be dropped
      clear_logs();
      u_mode = U_NEVER;
      post(0, 16'h1234, 1'b1);
      begin
         int k = 0;
         while (to_log.size() < 1 && k < 40) begin
            tick();
            k++;
         end
      end
      repeat (8) tick();
      chk("t4_timeout_seen", 32'(to_log.size()), 32'd1);
      chk("t4_tx_count",     32'(tx_log.size()), 32'd1);
      if (tx_log.size() >= 1 && to_log.size() >= 1) begin
         chk("t4_tx_lsb",     32'(tx_log[0]), 32'h34);
         chk("t4_latency",    32'(to_log[0] - txc_log[0]), 32'(BUSY_TIMEOUT + 1));
      end
      chk("t4_idle", 32'(Arb_busy), 32'd0);

      // Busy already high when the request arrives
      clear_logs();
      u_mode  = U_MANUAL;
      Tx_busy = 1'b1;
      post(0, 16'h00A0, 1'b0);
      repeat (5) tick();
      chk("t5_no_issue",    32'(tx_log.size()), 32'd0);
      chk("t5_arb_idle",    32'(Arb_busy),      32'd0);
      Tx_busy = 1'b0;
      tick();
      chk("t5_tx_valid",    32'(Tx_valid), 32'd1);
      chk("t5_tx_data",     32'(Tx_data),  32'hA0);
      tick();
      Tx_busy = 1'b1;
      repeat (2) tick();
      Tx_busy = 1'b0;
      repeat (2) tick();

      // Reset in the middle of a two-byte message
      post(1, 16'hBEEF, 1'b1);
      tick();
      chk("t6_lsb", 32'(Tx_data), 32'hEF);
      Tx_busy = 1'b1;
      repeat (2) tick();
      chk("t6_in_flight", 32'(Arb_busy), 32'd1);
      post(0, 16'h0077, 1'b0);
      post(1, 16'h3344, 1'b0);
      #2 Reset = 1'b0;
      #1;
      chk("t6_rst_tx_valid",    32'(Tx_valid),    32'd0);
      chk("t6_rst_tx_data",     32'(Tx_data),     32'd0);
      chk("t6_rst_req_ack",     32'(Req_ack),     32'd0);
      chk("t6_rst_arb_busy",    32'(Arb_busy),    32'd0);
      chk("t6_rst_timeout_err", 32'(Timeout_err), 32'd0);
      Tx_busy = 1'b0;
      repeat (2) tick();
      clear_logs();
      u_mode = U_NORMAL;
      Reset  = 1'b1;
      wait_tx(2, 80);
      drain(80);
      if (ack_log.size() >= 2 && tx_log.size() >= 2) begin
         chk("t6_first_grant",  32'(ack_log[0]), 32'd0);
         chk("t6_second_grant", 32'(ack_log[1]), 32'd1);
         chk("t6_first_byte",   32'(tx_log[0]),  32'h77);
         chk("t6_second_byte",  32'(tx_log[1]),  32'h44);
      end
      chk("t6_tx_count", 32'(tx_log.size()), 32'd2);

      // Randomized traffic with occasional unresponsive serializer phases
      auto_req = 1'b1;
      repeat (3000) begin
         tick();
         if ($urandom_range(0, 149) == 0)
            u_mode = (u_mode == U_NORMAL) ? U_NEVER : U_NORMAL;
      end
      auto_req = 1'b0;
      u_mode   = U_NORMAL;
      drain(500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART_Tx serializer among several on-chip requesters (register-file read-back, ALU result, status reporting). It accepts one- or two-byte messages, splits two-byte messages LSB-first, and drives the UART_Tx Data/Data_valid inputs. It paces issue on the UART_Tx Busy flag so no byte is ever offered while a frame is in flight.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TO_WIDTH, 3, width of the Busy-rise timeout counter
- BUSY_TIMEOUT, 4, cycles to wait for Busy to rise after a Tx_valid pulse (1..2^TO_WIDTH-1)

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Req_valid  in  NUM_REQ  per-requester request; held high until matching Req_ack
- Req_data  in  16*NUM_REQ  requester i occupies bits [16i+15:16i]
- Req_two_byte  in  NUM_REQ  1 = send LSB then MSB; 0 = send LSB only
- Req_ack  out  NUM_REQ  one-cycle pulse: request captured
- Tx_data  out  8  byte to UART_Tx Data
- Tx_valid  out  1  one-cycle pulse to UART_Tx Data_valid
- Tx_busy  in  1  UART_Tx Busy
- Arb_busy  out  1  high whenever the FSM is not IDLE
- Timeout_err  out  1  one-cycle pulse: Busy did not rise in time, message dropped

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: on an edge with any Req_valid=1 and Tx_busy=0, grant the first requester after last_grant (wrapping modulo NUM_REQ); latch its 16-bit data and two_byte flag; set last_grant; next state ISSUE. With Tx_busy=1, remain in IDLE.
- Req_ack[grant] is registered and high for exactly the first ISSUE cycle. A requester may change data or re-raise valid from the following cycle. Non-granted requests stay pending.
- ISSUE: Tx_valid=1 and Tx_data=current byte (LSB on the first pass, MSB on the second); next state WAIT_BUSY; clear the timeout counter.
- WAIT_BUSY: if Tx_busy=1, go to WAIT_DONE. Otherwise increment the counter; when it reaches BUSY_TIMEOUT, pulse Timeout_err, discard any remaining byte, and return to IDLE.
- WAIT_DONE: when Tx_busy=0, go to ISSUE with the MSB if a second byte is pending, else go to IDLE.
- Round-robin pointer last_grant resets to NUM_REQ-1, so requester 0 wins the first arbitration.
- Simultaneous requests: only one is granted per IDLE visit; the others are served in round-robin order on later visits.
- Reset mid-operation: abandon the message, no ack is replayed, and every output returns to its reset value immediately.

## Timing
- Reset values: Tx_valid=0, Tx_data=8'h00, Req_ack=0, Arb_busy=0, Timeout_err=0, state=IDLE, last_grant=NUM_REQ-1.
- All outputs are registered (Moore); no combinational path from input to output.
- Request edge (IDLE, Req_valid seen) -> Tx_valid high in the next cycle (latency 1), coincident with Req_ack.
- Tx_valid is never high for 2 consecutive cycles and is never high while Tx_busy=1 was last sampled high.
- Two-byte message: the MSB Tx_valid pulse occurs exactly 1 cycle after the edge on which Tx_busy is sampled low in WAIT_DONE.
- Minimum IDLE-to-IDLE time for a one-byte message: 3 cycles plus the UART frame time.

## Test plan
- Single one-byte request: req0 sends 16'h0055, two_byte=0 -> one Tx_valid with Tx_data=8'h55; Req_ack[0] in the same cycle; Arb_busy falls after Busy falls.
- Two-byte request: req1 sends 16'hA5C3, two_byte=1 -> Tx_data 8'hC3 then 8'hA5; the second pulse comes only after the first frame's Busy deasserts; no other issue in between.
- Contention: req0 and req1 held continuously -> grants alternate 0,1,0,1 across 4 messages; no starvation; each ack is a single pulse.
- Timeout: UART model never raises Busy -> Timeout_err pulses BUSY_TIMEOUT+1 cycles after Tx_valid; FSM returns to IDLE; the two-byte MSB is not sent.
- Busy at request: Tx_busy=1 while req0 is valid -> no grant until Busy=0, then normal issue.
- Reset mid-frame: drive Reset low during WAIT_DONE of a two-byte message -> all outputs 0 asynchronously; after release, requester 0 is granted first and no MSB is issued.
